// File: rtl/snake_pkg.sv
// Game-level definitions used by the menu renderer/selector.
// Holds the menu FSM state type, the button count limit and the default
// menu geometry/colours so every menu instance starts from the same layout.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LOCK  = 2'd2
  } menu_state_t;

  localparam int MENU_MAX_BUTTONS = 8;

  localparam int MENU_NUM_BUTTONS = 3;
  localparam int MENU_X           = 272;
  localparam int MENU_Y0          = 200;
  localparam int MENU_W           = 256;
  localparam int MENU_H           = 64;
  localparam int MENU_GAP         = 32;
  localparam int MENU_LOCK_FRAMES = 8;

  localparam logic [11:0] MENU_IDLE_COLOR  = 12'h0F0;
  localparam logic [11:0] MENU_HOVER_COLOR = 12'h0C0;
  localparam logic [11:0] MENU_PRESS_COLOR = 12'h080;

endpackage

// File: rtl/vga_pkg.sv
// Shared VGA definitions for the menu path.
// RGB_B is the width of one 4:4:4 pixel colour word.
package vga_pkg;

  localparam int RGB_B    = 12;
  localparam int HCOUNT_B = 11;
  localparam int VCOUNT_B = 11;

endpackage

// File: rtl/vga_if.sv
// VGA timing bundle passed between drawing stages.
// Modport "in" is the consumer view, "out" the producer view.
interface vga_if;
  import vga_pkg::*;

  logic [HCOUNT_B-1:0] hcount;
  logic [VCOUNT_B-1:0] vcount;
  logic                hblnk;
  logic                vblnk;
  logic                hsync;
  logic                vsync;

  modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync);
  modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync);

endinterface

// File: rtl/menu_button_ctrl.sv
// Mouse-side control for the menu: registers the mouse, detects left-button
// edges, runs the IDLE/PRESS/LOCK state machine and produces hover and
// selection outputs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              menu active; low forces IDLE and blocks selection
//   mouse_x/y/left      raw mouse inputs
//   vblnk               frame blanking, rising edge counts down the lockout
//   hit_valid/hit_idx   hit-test result for mouse_x_r/mouse_y_r (from top)
//   mouse_x_r/mouse_y_r registered mouse position fed to the hit test
//   hover_valid/idx     registered hit-test result
//   sel_valid/sel_idx   one-cycle selection pulse / last selected index
//   pressing/pressed_idx  button currently held down, for drawing
module menu_button_ctrl
  import snake_pkg::*;
#(
  parameter int IDX_W       = 2,
  parameter int LOCK_FRAMES = MENU_LOCK_FRAMES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [11:0]      mouse_x,
  input  logic [11:0]      mouse_y,
  input  logic             mouse_left,
  input  logic             vblnk,
  input  logic             hit_valid,
  input  logic [IDX_W-1:0] hit_idx,
  output logic [11:0]      mouse_x_r,
  output logic [11:0]      mouse_y_r,
  output logic             hover_valid,
  output logic [IDX_W-1:0] hover_idx,
  output logic             sel_valid,
  output logic [IDX_W-1:0] sel_idx,
  output logic             pressing,
  output logic [IDX_W-1:0] pressed_idx
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_PRESS = 2'(PRESS);
  localparam logic [1:0] ST_LOCK  = 2'(LOCK);

  localparam int LCW = (LOCK_FRAMES > 0) ? $clog2(LOCK_FRAMES + 1) : 1;

  logic [1:0]     state;
  logic [LCW-1:0] lock_cnt;
  logic           left_r;
  logic           left_prev;
  logic           vblnk_prev;
  logic           left_rise;
  logic           left_fall;
  logic           vblnk_rise;

  // Edges are taken on the registered button so they line up with the
  // registered hover result the state machine qualifies them with.
  assign left_rise  = left_r & ~left_prev;
  assign left_fall  = ~left_r & left_prev;
  assign vblnk_rise = vblnk & ~vblnk_prev;
  assign pressing   = (state == ST_PRESS);

  always_ff @(posedge clk) begin
    if (rst) begin
      mouse_x_r   <= '0;
      mouse_y_r   <= '0;
      left_r      <= 1'b0;
      left_prev   <= 1'b0;
      vblnk_prev  <= 1'b0;
      hover_valid <= 1'b0;
      hover_idx   <= '0;
      sel_valid   <= 1'b0;
      sel_idx     <= '0;
      pressed_idx <= '0;
      lock_cnt    <= '0;
      state       <= ST_IDLE;
    end else begin
      mouse_x_r   <= mouse_x;
      mouse_y_r   <= mouse_y;
      left_r      <= mouse_left;
      left_prev   <= left_r;
      vblnk_prev  <= vblnk;
      hover_valid <= hit_valid;
      hover_idx   <= hit_idx;
      sel_valid   <= 1'b0;

      if (!enable) begin
        state    <= ST_IDLE;
        lock_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (left_rise && hover_valid && lock_cnt == '0) begin
              state       <= ST_PRESS;
              pressed_idx <= hover_idx;
            end
          end
          ST_PRESS: begin
            // Releasing anywhere but the pressed button cancels the press.
            if (left_fall) begin
              if (hover_valid && hover_idx == pressed_idx) begin
                state     <= ST_LOCK;
                sel_valid <= 1'b1;
                sel_idx   <= pressed_idx;
                lock_cnt  <= LCW'(LOCK_FRAMES);
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_LOCK: begin
            // A zero count (LOCK_FRAMES = 0) leaves immediately.
            if (lock_cnt == '0) begin
              state <= ST_IDLE;
            end else if (vblnk_rise) begin
              lock_cnt <= lock_cnt - LCW'(1);
              if (lock_cnt == LCW'(1)) state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/draw_menu_sel.sv
// Menu renderer and selector. Draws NUM_BUTTONS vertically stacked buttons
// over the incoming pixel stream, coloured idle/hover/pressed, and reports
// hover and one-cycle selection pulses from the mouse.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   enable               menu active (drawing continues when low)
//   mouse_x/y/left       mouse position and left button level
//   vga_in, rgb_i        upstream timing and pixel colour
//   vga_out, rgb_o       timing and colour, 2 cycles later
//   hover_valid/idx      button under the mouse
//   sel_valid/sel_idx    selection pulse and last selected button
module draw_menu_sel
  import snake_pkg::*;
  import vga_pkg::*;
#(
  parameter int               NUM_BUTTONS = MENU_NUM_BUTTONS,
  parameter int               X           = MENU_X,
  parameter int               Y0          = MENU_Y0,
  parameter int               W           = MENU_W,
  parameter int               H           = MENU_H,
  parameter int               GAP         = MENU_GAP,
  parameter logic [RGB_B-1:0] IDLE_COLOR  = MENU_IDLE_COLOR,
  parameter logic [RGB_B-1:0] HOVER_COLOR = MENU_HOVER_COLOR,
  parameter logic [RGB_B-1:0] PRESS_COLOR = MENU_PRESS_COLOR,
  parameter int               LOCK_FRAMES = MENU_LOCK_FRAMES,
  localparam int              IDX_W       = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [11:0]      mouse_x,
  input  logic [11:0]      mouse_y,
  input  logic             mouse_left,
  vga_if.in                vga_in,
  input  logic [RGB_B-1:0] rgb_i,
  vga_if.out               vga_out,
  output logic [RGB_B-1:0] rgb_o,
  output logic             hover_valid,
  output logic [IDX_W-1:0] hover_idx,
  output logic             sel_valid,
  output logic [IDX_W-1:0] sel_idx
);

  // Returns {hit, index}. Scanning from the top index down lets the lowest
  // matching index overwrite the others, so overlaps resolve to the lowest.
  function automatic logic [IDX_W:0] hit_test(input logic [11:0] px,
                                               input logic [11:0] py);
    logic [IDX_W:0] res;
    int             top;
    res = '0;
    for (int k = NUM_BUTTONS - 1; k >= 0; k--) begin
      top = Y0 + k * (H + GAP);
      if (int'(px) >= X && int'(px) < X + W &&
          int'(py) >= top && int'(py) < top + H)
        res = {1'b1, IDX_W'(k)};
    end
    return res;
  endfunction

  logic             pix_hit;
  logic [IDX_W-1:0] pix_idx;
  logic [11:0]      mouse_x_r;
  logic [11:0]      mouse_y_r;
  logic             mouse_hit;
  logic [IDX_W-1:0] mouse_idx;
  logic             pressing;
  logic [IDX_W-1:0] pressed_idx;

  logic [HCOUNT_B-1:0] s1_hcount;
  logic [VCOUNT_B-1:0] s1_vcount;
  logic                s1_hblnk;
  logic                s1_vblnk;
  logic                s1_hsync;
  logic                s1_vsync;
  logic [RGB_B-1:0]    s1_rgb;
  logic                s1_hit;
  logic [IDX_W-1:0]    s1_idx;
  logic [RGB_B-1:0]    pix_color;

  assign {pix_hit, pix_idx}     = hit_test(12'(vga_in.hcount), 12'(vga_in.vcount));
  assign {mouse_hit, mouse_idx} = hit_test(mouse_x_r, mouse_y_r);

  menu_button_ctrl #(
    .IDX_W       (IDX_W),
    .LOCK_FRAMES (LOCK_FRAMES)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mouse_x     (mouse_x),
    .mouse_y     (mouse_y),
    .mouse_left  (mouse_left),
    .vblnk       (vga_in.vblnk),
    .hit_valid   (mouse_hit),
    .hit_idx     (mouse_idx),
    .mouse_x_r   (mouse_x_r),
    .mouse_y_r   (mouse_y_r),
    .hover_valid (hover_valid),
    .hover_idx   (hover_idx),
    .sel_valid   (sel_valid),
    .sel_idx     (sel_idx),
    .pressing    (pressing),
    .pressed_idx (pressed_idx)
  );

  // Pressed beats hovered; both only apply to the button they name.
  always_comb begin
    pix_color = s1_rgb;
    if (s1_hit) begin
      if (pressing && s1_idx == pressed_idx)
        pix_color = PRESS_COLOR;
      else if (hover_valid && s1_idx == hover_idx)
        pix_color = HOVER_COLOR;
      else
        pix_color = IDLE_COLOR;
    end
    if (s1_hblnk || s1_vblnk) pix_color = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hcount      <= '0;
      s1_vcount      <= '0;
      s1_hblnk       <= 1'b0;
      s1_vblnk       <= 1'b0;
      s1_hsync       <= 1'b0;
      s1_vsync       <= 1'b0;
      s1_rgb         <= '0;
      s1_hit         <= 1'b0;
      s1_idx         <= '0;
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      rgb_o          <= '0;
    end else begin
      s1_hcount      <= vga_in.hcount;
      s1_vcount      <= vga_in.vcount;
      s1_hblnk       <= vga_in.hblnk;
      s1_vblnk       <= vga_in.vblnk;
      s1_hsync       <= vga_in.hsync;
      s1_vsync       <= vga_in.vsync;
      s1_rgb         <= rgb_i;
      s1_hit         <= pix_hit;
      s1_idx         <= pix_idx;
      vga_out.hcount <= s1_hcount;
      vga_out.vcount <= s1_vcount;
      vga_out.hblnk  <= s1_hblnk;
      vga_out.vblnk  <= s1_vblnk;
      vga_out.hsync  <= s1_hsync;
      vga_out.vsync  <= s1_vsync;
      rgb_o          <= pix_color;
    end
  end

endmodule

// File: tb/tb_draw_menu_sel.sv
// Self-checking bench for draw_menu_sel with default parameters.
// Directed scenarios check fixed values; a random phase compares every
// cycle against a reference model built from the button geometry rules.
`timescale 1ns/1ps
module tb_draw_menu_sel;

  localparam int NB = 3, BX = 272, BY0 = 200, BW = 256, BH = 64, BGAP = 32, LOCKF = 8;
  localparam logic [11:0] C_IDLE = 12'h0F0, C_HOVER = 12'h0C0, C_PRESS = 12'h080;

  logic        clk = 1'b0;
  logic        rst, enable, mouse_left;
  logic [11:0] mouse_x, mouse_y, rgb_i, rgb_o;
  logic        hover_valid, sel_valid;
  logic [1:0]  hover_idx, sel_idx;
  int          n_checks = 0;
  int          n_fail   = 0;

  vga_if vin();
  vga_if vout();

  always #5 clk = ~clk;

  draw_menu_sel dut (
    .clk(clk), .rst(rst), .enable(enable),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .mouse_left(mouse_left),
    .vga_in(vin), .rgb_i(rgb_i), .vga_out(vout), .rgb_o(rgb_o),
    .hover_valid(hover_valid), .hover_idx(hover_idx),
    .sel_valid(sel_valid), .sel_idx(sel_idx)
  );

  // Reference: index of the button containing (px,py), or -1.
  function automatic int ref_button(int px, int py);
    int pitch, k;
    pitch = BH + BGAP;
    if (px < BX || px >= BX + BW || py < BY0) return -1;
    k = (py - BY0) / pitch;
    if (k >= NB || (py - BY0) % pitch >= BH) return -1;
    return k;
  endfunction

  typedef enum int {M_IDLE, M_PRESS, M_LOCK} mstate_t;
  typedef struct packed {
    logic [10:0] h; logic [10:0] v;
    logic hb; logic vb; logic hs; logic vs;
    logic [11:0] rgb;
  } pix_t;

  mstate_t     m_state;
  int          m_pidx, m_cnt, m_hover, m_sel_idx;
  bit          m_sel;
  int          mx1, my1;
  bit          ml1, ml2, vb1;
  pix_t        pix1, e_pix;
  logic [11:0] e_rgb;

  // Reference model: a click is judged on the button level seen one and two
  // samples back, against the mouse position two samples back.
  always @(posedge clk) begin : ref_model
    int b;
    bit rise, fall, vrise;
    if (rst) begin
      m_state = M_IDLE; m_pidx = 0; m_cnt = 0; m_hover = -1; m_sel_idx = 0; m_sel = 0;
      mx1 = 0; my1 = 0; ml1 = 0; ml2 = 0; vb1 = 0;
      pix1 = '0; e_pix = '0; e_rgb = '0;
    end else begin
      e_pix = pix1;
      b = ref_button(int'(pix1.h), int'(pix1.v));
      if (pix1.hb || pix1.vb)                      e_rgb = 12'h000;
      else if (b < 0)                              e_rgb = pix1.rgb;
      else if (m_state == M_PRESS && b == m_pidx)  e_rgb = C_PRESS;
      else if (b == m_hover)                       e_rgb = C_HOVER;
      else                                         e_rgb = C_IDLE;
      rise  = ml1 && !ml2;
      fall  = !ml1 && ml2;
      vrise = vin.vblnk && !vb1;
      m_sel = 0;
      if (!enable) begin
        m_state = M_IDLE; m_cnt = 0;
      end else if (m_state == M_IDLE) begin
        if (rise && m_hover >= 0 && m_cnt == 0) begin m_state = M_PRESS; m_pidx = m_hover; end
      end else if (m_state == M_PRESS) begin
        if (fall) begin
          if (m_hover == m_pidx) begin
            m_sel = 1; m_sel_idx = m_pidx; m_cnt = LOCKF; m_state = M_LOCK;
          end else m_state = M_IDLE;
        end
      end else begin
        if (m_cnt == 0) m_state = M_IDLE;
        else if (vrise) begin
          m_cnt--;
          if (m_cnt == 0) m_state = M_IDLE;
        end
      end
      m_hover = ref_button(mx1, my1);
      mx1 = int'(mouse_x); my1 = int'(mouse_y);
      ml2 = ml1; ml1 = mouse_left; vb1 = vin.vblnk;
      pix1 = {vin.hcount, vin.vcount, vin.hblnk, vin.vblnk, vin.hsync, vin.vsync, rgb_i};
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pixel(int h, int v, logic [11:0] c);
    vin.hcount = 11'(h); vin.vcount = 11'(v);
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    rgb_i = c;
  endtask

  task automatic set_mouse(int x, int y);
    mouse_x = 12'(x); mouse_y = 12'(y);
  endtask

  task automatic vblnk_pulses(int n);
    repeat (n) begin
      vin.vblnk = 1'b1; tick(1);
      vin.vblnk = 1'b0; tick(1);
    end
  endtask

  // Press, release, then count selection pulses in a fixed window.
  task automatic click(output int cnt, output logic [1:0] idx);
    mouse_left = 1'b1; tick(3);
    mouse_left = 1'b0;
    cnt = 0; idx = 2'b11;
    repeat (8) begin
      tick(1);
      if (sel_valid) begin cnt++; idx = sel_idx; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; mouse_left = 1'b0;
    set_mouse(300, 310);
    set_pixel(300, 300, 12'hFFF);
    vin.hsync = 1'b1; vin.vsync = 1'b1;
    tick(3);
    n_checks++;
    if ({vout.hcount, vout.vcount, vout.hblnk, vout.vblnk, vout.hsync, vout.vsync} !== 26'd0) begin
      n_fail++; $display("[TB] FAIL reset_vga: got %h expected 0",
        {vout.hcount, vout.vcount, vout.hblnk, vout.vblnk, vout.hsync, vout.vsync});
    end
    n_checks++;
    if (rgb_o !== 12'h000) begin n_fail++; $display("[TB] FAIL reset_rgb: got %h expected 000", rgb_o); end
    n_checks++;
    if ({hover_valid, hover_idx, sel_valid, sel_idx} !== 6'd0) begin
      n_fail++; $display("[TB] FAIL reset_ctrl: got %b expected 0", {hover_valid, hover_idx, sel_valid, sel_idx});
    end
    rst = 1'b0;
    set_mouse(1000, 1000);
  endtask

  task automatic test_defaults();
    set_pixel(10, 10, 12'h000); tick(3);
    set_pixel(300, 210, 12'hAAA); tick(1);
    n_checks++;
    if (vout.hcount !== 11'd10) begin n_fail++; $display("[TB] FAIL latency_early: got %0d expected 10", vout.hcount); end
    tick(1);
    n_checks++;
    if (vout.hcount !== 11'd300 || vout.vcount !== 11'd210) begin
      n_fail++; $display("[TB] FAIL latency_2: got %0d,%0d expected 300,210", vout.hcount, vout.vcount);
    end
    n_checks++;
    if (rgb_o !== C_IDLE) begin n_fail++; $display("[TB] FAIL idle_fill: got %h expected %h", rgb_o, C_IDLE); end
    set_pixel(271, 210, 12'hAAA); tick(2);
    n_checks++;
    if (rgb_o !== 12'hAAA) begin n_fail++; $display("[TB] FAIL left_edge: got %h expected AAA", rgb_o); end
    set_pixel(300, 264, 12'hAAA); tick(2);
    n_checks++;
    if (rgb_o !== 12'hAAA) begin n_fail++; $display("[TB] FAIL gap_row: got %h expected AAA", rgb_o); end
    set_pixel(527, 263, 12'hAAA); tick(2);
    n_checks++;
    if (rgb_o !== C_IDLE) begin n_fail++; $display("[TB] FAIL last_corner: got %h expected %h", rgb_o, C_IDLE); end
    set_pixel(528, 210, 12'hAAA); tick(2);
    n_checks++;
    if (rgb_o !== 12'hAAA) begin n_fail++; $display("[TB] FAIL right_edge: got %h expected AAA", rgb_o); end
    set_pixel(300, 210, 12'hAAA); vin.hblnk = 1'b1; tick(2);
    n_checks++;
    if (rgb_o !== 12'h000 || vout.hblnk !== 1'b1) begin
      n_fail++; $display("[TB] FAIL blank: got rgb %h hblnk %b expected 000 1", rgb_o, vout.hblnk);
    end
    vin.hblnk = 1'b0;
  endtask

  task automatic test_hover();
    set_mouse(300, 310); tick(1);
    n_checks++;
    if (hover_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL hover_early: got %b expected 0", hover_valid); end
    tick(1);
    n_checks++;
    if (hover_valid !== 1'b1 || hover_idx !== 2'd1) begin
      n_fail++; $display("[TB] FAIL hover_btn1: got %b/%0d expected 1/1", hover_valid, hover_idx);
    end
    set_pixel(300, 300, 12'hAAA); tick(2);
    n_checks++;
    if (rgb_o !== C_HOVER) begin n_fail++; $display("[TB] FAIL hover_fill: got %h expected %h", rgb_o, C_HOVER); end
    set_pixel(300, 210, 12'hAAA); tick(2);
    n_checks++;
    if (rgb_o !== C_IDLE) begin n_fail++; $display("[TB] FAIL other_idle: got %h expected %h", rgb_o, C_IDLE); end
  endtask

  task automatic test_select();
    int cnt; logic [1:0] idx;
    set_mouse(300, 310); tick(3);
    mouse_left = 1'b1; tick(3);
    set_pixel(300, 300, 12'hAAA); tick(2);
    n_checks++;
    if (rgb_o !== C_PRESS) begin n_fail++; $display("[TB] FAIL press_fill: got %h expected %h", rgb_o, C_PRESS); end
    set_mouse(300, 320); tick(3);
    mouse_left = 1'b0;
    cnt = 0; idx = 2'b11;
    repeat (8) begin tick(1); if (sel_valid) begin cnt++; idx = sel_idx; end end
    n_checks++;
    if (cnt != 1 || idx !== 2'd1) begin n_fail++; $display("[TB] FAIL select_pulse: got %0d pulses idx %0d expected 1 idx 1", cnt, idx); end
    vblnk_pulses(LOCKF);
  endtask

  task automatic test_cancel();
    int cnt;
    set_mouse(300, 310); tick(3);
    mouse_left = 1'b1; tick(3);
    set_mouse(300, 410); tick(3);
    mouse_left = 1'b0;
    cnt = 0;
    repeat (8) begin tick(1); if (sel_valid) cnt++; end
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("[TB] FAIL cancel_pulse: got %0d pulses expected 0", cnt); end
    n_checks++;
    if (sel_idx !== 2'd1) begin n_fail++; $display("[TB] FAIL cancel_hold_idx: got %0d expected 1", sel_idx); end
    set_pixel(300, 300, 12'hAAA); tick(2);
    n_checks++;
    if (rgb_o !== C_IDLE) begin n_fail++; $display("[TB] FAIL cancel_idle: got %h expected %h", rgb_o, C_IDLE); end
    set_pixel(300, 400, 12'hAAA); tick(2);
    n_checks++;
    if (rgb_o !== C_HOVER) begin n_fail++; $display("[TB] FAIL cancel_hover2: got %h expected %h", rgb_o, C_HOVER); end
  endtask

  task automatic test_lockout();
    int cnt; logic [1:0] idx;
    set_mouse(300, 210); tick(3);
    click(cnt, idx);
    n_checks++;
    if (cnt != 1 || idx !== 2'd0) begin n_fail++; $display("[TB] FAIL lock_first: got %0d idx %0d expected 1 idx 0", cnt, idx); end
    click(cnt, idx);
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("[TB] FAIL lock_immediate: got %0d expected 0", cnt); end
    vblnk_pulses(LOCKF - 1);
    click(cnt, idx);
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("[TB] FAIL lock_7_frames: got %0d expected 0", cnt); end
    vblnk_pulses(1);
    click(cnt, idx);
    n_checks++;
    if (cnt != 1 || idx !== 2'd0) begin n_fail++; $display("[TB] FAIL lock_expired: got %0d idx %0d expected 1 idx 0", cnt, idx); end
    vblnk_pulses(LOCKF);
  endtask

  task automatic test_enable();
    int cnt; logic [1:0] idx;
    set_mouse(300, 310); tick(3);
    mouse_left = 1'b1; tick(3);
    mouse_left = 1'b0; enable = 1'b0;
    cnt = 0;
    repeat (4) begin tick(1); if (sel_valid) cnt++; end
    set_pixel(300, 300, 12'hAAA); tick(2);
    n_checks++;
    if (rgb_o !== C_HOVER) begin n_fail++; $display("[TB] FAIL disabled_draw: got %h expected %h", rgb_o, C_HOVER); end
    enable = 1'b1;
    repeat (6) begin tick(1); if (sel_valid) cnt++; end
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("[TB] FAIL disabled_pulse: got %0d expected 0", cnt); end
    click(cnt, idx);
    n_checks++;
    if (cnt != 1 || idx !== 2'd1) begin n_fail++; $display("[TB] FAIL reenabled: got %0d idx %0d expected 1 idx 1", cnt, idx); end
    vblnk_pulses(LOCKF);
  endtask

  task automatic test_reset_mid_press();
    int cnt;
    set_mouse(300, 310); tick(3);
    mouse_left = 1'b1; tick(3);
    set_pixel(300, 300, 12'hAAA); tick(2);
    n_checks++;
    if (rgb_o !== C_PRESS) begin n_fail++; $display("[TB] FAIL midpress_fill: got %h expected %h", rgb_o, C_PRESS); end
    rst = 1'b1; tick(1);
    n_checks++;
    if ({hover_valid, hover_idx, sel_valid, sel_idx, rgb_o} !== 18'd0 ||
        {vout.hcount, vout.vcount, vout.hblnk, vout.vblnk, vout.hsync, vout.vsync} !== 26'd0) begin
      n_fail++; $display("[TB] FAIL midpress_reset: got %h/%h expected 0/0",
        {hover_valid, hover_idx, sel_valid, sel_idx, rgb_o},
        {vout.hcount, vout.vcount, vout.hblnk, vout.vblnk, vout.hsync, vout.vsync});
    end
    rst = 1'b0; tick(4);
    mouse_left = 1'b0;
    cnt = 0;
    repeat (8) begin tick(1); if (sel_valid) cnt++; end
    n_checks++;
    if (cnt != 0) begin n_fail++; $display("[TB] FAIL midpress_abort: got %0d expected 0", cnt); end
  endtask

  task automatic test_random();
    logic [25:0] got_t, exp_t;
    for (int i = 0; i < 4000; i++) begin
      tick(1);
      got_t = {vout.hcount, vout.vcount, vout.hblnk, vout.vblnk, vout.hsync, vout.vsync};
      exp_t = {e_pix.h, e_pix.v, e_pix.hb, e_pix.vb, e_pix.hs, e_pix.vs};
      n_checks++;
      if (got_t !== exp_t) begin n_fail++; $display("[TB] FAIL rand_timing @%0d: got %h expected %h", i, got_t, exp_t); end
      n_checks++;
      if (rgb_o !== e_rgb) begin n_fail++; $display("[TB] FAIL rand_rgb @%0d: got %h expected %h", i, rgb_o, e_rgb); end
      n_checks++;
      if (hover_valid !== (m_hover >= 0) || hover_idx !== ((m_hover >= 0) ? 2'(m_hover) : 2'd0)) begin
        n_fail++; $display("[TB] FAIL rand_hover @%0d: got %b/%0d expected %0d", i, hover_valid, hover_idx, m_hover);
      end
      n_checks++;
      if (sel_valid !== m_sel || sel_idx !== 2'(m_sel_idx)) begin
        n_fail++; $display("[TB] FAIL rand_sel @%0d: got %b/%0d expected %b/%0d", i, sel_valid, sel_idx, m_sel, m_sel_idx);
      end
      rst    = ($urandom_range(0, 599) == 0);
      enable = ($urandom_range(0, 31) != 0);
      if ($urandom_range(0, 7) == 0) set_mouse($urandom_range(240, 560), $urandom_range(180, 480));
      if ($urandom_range(0, 9) == 0) mouse_left = ~mouse_left;
      vin.hcount = 11'($urandom_range(240, 560));
      vin.vcount = 11'($urandom_range(180, 480));
      vin.hblnk  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0) vin.vblnk = ~vin.vblnk;
      vin.hsync  = 1'($urandom_range(0, 1));
      vin.vsync  = 1'($urandom_range(0, 1));
      rgb_i      = 12'($urandom);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_hover();
    test_select();
    test_cancel();
    test_lockout();
    test_enable();
    test_reset_mid_press();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_menu_sel.md
Name: draw_menu_sel

Overview:
Parametrised menu renderer and selector. Draws NUM_BUTTONS vertically stacked buttons over an incoming pixel stream and colours each one by state (idle, hover, pressed). Tracks mouse hover and click, and emits a one-cycle selection pulse carrying the button index. Sits in the menu path between the background stage and the text/mouse overlay stages, and feeds the game-mode controller.

Parameters:
NUM_BUTTONS, 3, number of buttons (1..8)
X, 272, left edge of all buttons (pixels)
Y0, 200, top edge of button 0
W, 256, button width
H, 64, button height
GAP, 32, vertical gap between buttons; button k top = Y0 + k*(H+GAP)
IDLE_COLOR, 12'h0F0, fill for idle button
HOVER_COLOR, 12'h0C0, fill for hovered button
PRESS_COLOR, 12'h080, fill for pressed button
LOCK_FRAMES, 8, frames during which clicks are ignored after a selection (0 = no lockout)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  menu active; low forces FSM to IDLE and suppresses selection
mouse_x  in  12  mouse x position
mouse_y  in  12  mouse y position
mouse_left  in  1  left button level
vga_in  vga_if.in  -  timing in (hcount, vcount, hblnk, vblnk, hsync, vsync)
rgb_i  in  RGB_B  upstream pixel colour
vga_out  vga_if.out  -  timing out, delayed 2 cycles
rgb_o  out  RGB_B  pixel colour, aligned with vga_out
hover_valid  out  1  mouse is over some button
hover_idx  out  $clog2(NUM_BUTTONS) (min 1)  hovered button index
sel_valid  out  1  one-cycle selection pulse
sel_idx  out  $clog2(NUM_BUTTONS) (min 1)  selected index; held until next selection

Behaviour:
- Clock is clk; reset is synchronous and active-high (rst). All outputs are 0 on reset, including every vga_out field and rgb_o. FSM goes to IDLE and the lock counter is cleared.
- Hit test: a point is in button k iff X <= px < X+W and Yk <= py < Yk+H (half-open intervals). If no button matches, the point is a miss. With GAP >= 0 the buttons cannot overlap; on any overlap the lowest index wins.
- Pixel pipeline, 2 stages:
  - S1 registers the vga_in fields and rgb_i, plus the pixel hit index and hit flag.
  - S2 picks the colour. A miss passes rgb_i through. A hit on the pressed button (state PRESS) uses PRESS_COLOR. A hit on the hovered button uses HOVER_COLOR. Any other hit uses IDLE_COLOR.
  - While hblnk or vblnk is set, rgb_o = 0.
  - Latency is exactly 2 cycles for all fields.
- Mouse path: mouse_x, mouse_y and mouse_left are registered once. The hit test runs on the registered values and its result is registered into hover_valid/hover_idx, so hover reflects the mouse 2 cycles after it changes.
- A left-button edge is detected on the registered mouse_left against its previous value.
- FSM states IDLE, PRESS, LOCK:
  - IDLE -> PRESS on a rising left edge with hover_valid and lock counter = 0. pressed_idx latches hover_idx.
  - PRESS -> LOCK on a falling left edge with hover_valid and hover_idx == pressed_idx. That cycle sel_valid = 1 and sel_idx = pressed_idx. The lock counter loads LOCK_FRAMES.
  - PRESS -> IDLE on a falling edge over another button or over no button. The press is cancelled and no pulse is emitted.
  - LOCK decrements the counter on each rising edge of vga_in.vblnk and moves to IDLE when it reaches 0. With LOCK_FRAMES = 0, LOCK exits to IDLE on the next cycle.
  - A rising left edge in LOCK is ignored. A later press requires a fresh edge.
- enable = 0 forces IDLE, clears the counter and blocks sel_valid, even when a qualifying release occurs in the same cycle. Drawing continues.
- A reset mid-PRESS aborts the press with no pulse.
- Rising and falling edges cannot coincide; the edge detector is single-bit.

Decomposition:
- snake_pkg: typedef enum menu_state_t {IDLE, PRESS, LOCK}; MENU_MAX_BUTTONS = 8; default menu geometry constants.
- vga_pkg: RGB_B.
- Sub-module menu_button_ctrl: mouse registering, edge detection, FSM, lock counter, sel/hover outputs.
- The top level holds the geometry hit-test function (shared by pixel and mouse paths) and the pixel pipeline.

Test Plan:
1. Defaults. vga_in hcount=300, vcount=210, rgb_i=AAA, mouse far away -> 2 cycles later rgb_o=0F0. At hcount=271 -> rgb_o=AAA. At vcount=264 (gap) -> AAA.
2. Mouse at (300,310) -> hover_valid=1, hover_idx=1 after 2 cycles. A pixel at (300,300) -> 0C0; a pixel at (300,210) -> 0F0.
3. Press at (300,310), release at (300,320) -> one cycle of sel_valid=1 with sel_idx=1. The button draws 080 while pressed.
4. Press on button 1, move to (300,410), release -> no sel_valid, FSM back in IDLE, sel_idx keeps its old value.
5. A selection followed by an immediate second click -> ignored until 8 vblnk rising edges; a click after that selects normally.
6. Drop enable in the same cycle as a qualifying release -> no pulse. rst asserted mid-PRESS -> all outputs 0 next cycle.
